// File: rtl/cpu_oci_dct_packer.sv
// Purpose: OCI debug-compressed-trace packer. Packs 2-bit trace atoms into a
//          30-bit DCT buffer and ships each full or flushed buffer as one
//          36-bit trace word over a valid/ready handshake.
// Latency: the DEPTH-th atom accepted at edge N gives tw_valid after edge N+1
//          when the output register is free; flushes take one extra cycle.
// Backpressure: atom_ready drops while the buffer is held (full or flush
//          pending) and waits for the output register; atoms are never dropped.
// Ports: clk/reset (sync, active-high); atom_valid/atom/atom_ready atom input;
//        flush/flush_done flush request and completion pulse;
//        tw_valid/tw_data/tw_ready trace word output; dct_buffer/dct_count
//        live monitor view of the packing buffer.
// Optional: define DCT_IDLE_FLUSH_EN to auto-flush a partial buffer after
//           IDLE_FLUSH_CYCLES idle cycles (no flush_done pulse for those).
module cpu_oci_dct_packer #(
  parameter int DEPTH             = 15,
  parameter int IDLE_FLUSH_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        atom_valid,
  input  logic [1:0]  atom,
  output logic        atom_ready,
  input  logic        flush,
  output logic        flush_done,
  output logic        tw_valid,
  output logic [35:0] tw_data,
  input  logic        tw_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count
);

  if (DEPTH < 1 || DEPTH > 15) begin : g_bad_depth
    $error("cpu_oci_dct_packer: DEPTH must be in 1..15");
  end
  if (IDLE_FLUSH_CYCLES < 1) begin : g_bad_idle
    $error("cpu_oci_dct_packer: IDLE_FLUSH_CYCLES must be >= 1");
  end

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [29:0] buf_nxt;
  logic [3:0]  cnt_nxt;
  logic        flush_pend, pend_nxt;
  logic        auto_pend, auto_nxt;
  logic        auto_set;
  logic        tw_valid_nxt;
  logic [35:0] tw_data_nxt;
  logic        done_c;
  logic        accept;
  logic        transfer;

  // atom_ready is held low while reset is asserted so every output reads 0
  // during reset.
  assign atom_ready = (state == FILL) && !reset;
  assign accept     = atom_valid && atom_ready;
  assign transfer   = (state == HOLD) && (!tw_valid || tw_ready);
  assign flush_done = done_c && !reset;

`ifdef DCT_IDLE_FLUSH_EN
  localparam int IW = $clog2(IDLE_FLUSH_CYCLES + 1);
  logic [IW-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (accept || transfer) begin
      idle_cnt <= '0;
    end else if (dct_count != 4'd0 && idle_cnt < IW'(IDLE_FLUSH_CYCLES)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Fires on the cycle whose increment makes the counter reach the timeout.
  assign auto_set = (idle_cnt == IW'(IDLE_FLUSH_CYCLES - 1)) &&
                    (dct_count != 4'd0) && !accept && !transfer;
`else
  assign auto_set = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    buf_nxt      = dct_buffer;
    cnt_nxt      = dct_count;
    pend_nxt     = flush_pend || flush;
    auto_nxt     = auto_pend || auto_set;
    tw_valid_nxt = tw_valid && !tw_ready;
    tw_data_nxt  = tw_data;
    done_c       = 1'b0;

    case (state)
      FILL: begin
        if (accept) begin
          buf_nxt = {dct_buffer[27:0], atom};
          cnt_nxt = dct_count + 4'd1;
        end
        // A flush against an empty buffer completes without emitting a word.
        // A repeat flush pulse while pending is absorbed here.
        if ((flush_pend || auto_pend) && dct_count == 4'd0) begin
          done_c   = flush_pend;
          pend_nxt = 1'b0;
          auto_nxt = 1'b0;
        end
        // Decide on next-cycle contents so a flush arriving with an atom
        // includes that atom in the flushed word.
        if (cnt_nxt == DEPTH_C || ((pend_nxt || auto_nxt) && cnt_nxt != 4'd0)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (transfer) begin
          tw_valid_nxt = 1'b1;
          tw_data_nxt  = {2'b01, dct_count, dct_buffer};
          buf_nxt      = '0;
          cnt_nxt      = 4'd0;
          done_c       = flush_pend;
          pend_nxt     = 1'b0;
          auto_nxt     = 1'b0;
          state_nxt    = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      dct_buffer <= '0;
      dct_count  <= 4'd0;
      flush_pend <= 1'b0;
      auto_pend  <= 1'b0;
      tw_valid   <= 1'b0;
      tw_data    <= '0;
    end else begin
      state      <= state_nxt;
      dct_buffer <= buf_nxt;
      dct_count  <= cnt_nxt;
      flush_pend <= pend_nxt;
      auto_pend  <= auto_nxt;
      tw_valid   <= tw_valid_nxt;
      tw_data    <= tw_data_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_oci_dct_packer.sv
// Purpose: self-checking bench for cpu_oci_dct_packer. Directed stimulus pushes
//          expected trace words into a queue; a negedge monitor pops and
//          compares every delivered word and checks held words stay stable.
module tb_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom = 2'b00;
  logic        flush = 1'b0;
  logic        tw_ready = 1'b0;
  logic        atom_ready;
  logic        flush_done;
  logic        tw_valid;
  logic [35:0] tw_data;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;

  int checks = 0;
  int errs = 0;
  int words_seen = 0;
  logic [35:0] exp_q[$];

  localparam logic [35:0] W_ONES  = 36'h7_FFFF_FFFF;
  localparam logic [35:0] W_THREE = 36'h4_C000_001B;
  localparam logic [35:0] W_TWO   = 36'h4_8000_000C;
  localparam logic [35:0] W_TENS  = 36'h7_EAAA_AAAA;
  localparam logic [35:0] W_ONESP = 36'h7_D555_5555;

  cpu_oci_dct_packer #(.DEPTH(15), .IDLE_FLUSH_CYCLES(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .atom_valid (atom_valid),
    .atom       (atom),
    .atom_ready (atom_ready),
    .flush      (flush),
    .flush_done (flush_done),
    .tw_valid   (tw_valid),
    .tw_data    (tw_data),
    .tw_ready   (tw_ready),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one atom (optionally with flush) and return just after it is taken.
  task automatic put_atom(input logic [1:0] a, input logic fl);
    int n = 0;
    atom_valid = 1'b1;
    atom       = a;
    flush      = fl;
    @(negedge clk);
    while (!atom_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!atom_ready) begin
      checks++;
      errs++;
      $display("FAIL atom_timeout: atom_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    atom_valid = 1'b0;
    flush      = 1'b0;
  endtask

  // Scoreboard monitor.
  logic        prev_hold = 1'b0;
  logic [35:0] prev_dat = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && tw_valid) chk("tw_hold_stable", tw_data, prev_dat);
      if (tw_valid && tw_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_word: got %h, required no word", tw_data);
        end else begin
          chk("tw_data", tw_data, exp_q.pop_front());
        end
        words_seen++;
      end
      prev_hold = tw_valid && !tw_ready;
      prev_dat  = tw_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_tw_valid", 36'(tw_valid), 36'd0);
    chk("rst_tw_data", tw_data, 36'd0);
    chk("rst_buffer", 36'(dct_buffer), 36'd0);
    chk("rst_count", 36'(dct_count), 36'd0);
    chk("rst_flush_done", 36'(flush_done), 36'd0);
    chk("rst_atom_ready", 36'(atom_ready), 36'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_atom_ready", 36'(atom_ready), 36'd1);

    // 15 atoms of 2'b11 back-to-back
    step();
    tw_ready = 1'b1;
    exp_q.push_back(W_ONES);
    for (int i = 0; i < 15; i++) put_atom(2'b11, 1'b0);
    @(negedge clk);
    chk("full_count", 36'(dct_count), 36'd15);
    chk("full_no_valid_yet", 36'(tw_valid), 36'd0);
    chk("full_atom_ready", 36'(atom_ready), 36'd0);
    @(negedge clk);
    chk("full_tw_valid", 36'(tw_valid), 36'd1);
    chk("full_count_cleared", 36'(dct_count), 36'd0);
    @(negedge clk);
    chk("full_consumed", 36'(tw_valid), 36'd0);

    // Atoms 01,10,11 then flush
    step();
    exp_q.push_back(W_THREE);
    put_atom(2'b01, 1'b0);
    put_atom(2'b10, 1'b0);
    put_atom(2'b11, 1'b0);
    chk("three_buffer", 36'(dct_buffer), 36'h1B);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush3_done", 36'(flush_done), 36'd1);
    chk("flush3_atom_ready", 36'(atom_ready), 36'd0);
    chk("flush3_no_valid_yet", 36'(tw_valid), 36'd0);
    @(negedge clk);
    chk("flush3_done_low", 36'(flush_done), 36'd0);
    chk("flush3_tw_valid", 36'(tw_valid), 36'd1);

    // Flush with an empty buffer
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("flush0_done_early", 36'(flush_done), 36'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush0_done", 36'(flush_done), 36'd1);
    chk("flush0_no_word", 36'(tw_valid), 36'd0);
    step();
    @(negedge clk);
    chk("flush0_done_low", 36'(flush_done), 36'd0);
    chk("flush0_no_word2", 36'(tw_valid), 36'd0);

    // Flush together with an accepted atom
    step();
    exp_q.push_back(W_TWO);
    put_atom(2'b11, 1'b0);
    put_atom(2'b00, 1'b1);
    @(negedge clk);
    chk("flushA_done", 36'(flush_done), 36'd1);
    chk("flushA_count", 36'(dct_count), 36'd2);
    @(negedge clk);
    chk("flushA_tw_valid", 36'(tw_valid), 36'd1);

    // Backpressure: 30 atoms with tw_ready low
    step();
    tw_ready = 1'b0;
    exp_q.push_back(W_TENS);
    exp_q.push_back(W_ONESP);
    for (int i = 0; i < 15; i++) put_atom(2'b10, 1'b0);
    for (int i = 0; i < 15; i++) put_atom(2'b01, 1'b0);
    @(negedge clk);
    chk("bp_atom_ready", 36'(atom_ready), 36'd0);
    chk("bp_count", 36'(dct_count), 36'd15);
    chk("bp_held_word", tw_data, W_TENS);
    repeat (3) @(negedge clk);
    chk("bp_still_valid", 36'(tw_valid), 36'd1);
    step();
    tw_ready = 1'b1;
    @(negedge clk);
    chk("bp_first", tw_data, W_TENS);
    @(negedge clk);
    chk("bp_second_valid", 36'(tw_valid), 36'd1);
    chk("bp_second", tw_data, W_ONESP);
    @(negedge clk);
    chk("bp_drained", 36'(tw_valid), 36'd0);
    chk("bp_count_zero", 36'(dct_count), 36'd0);

    // Reset mid-operation discards the held word and partial buffer
    step();
    tw_ready = 1'b0;
    for (int i = 0; i < 3; i++) put_atom(2'b10, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 7; i++) put_atom(2'b11, 1'b0);
    @(negedge clk);
    chk("mid_tw_valid", 36'(tw_valid), 36'd1);
    chk("mid_count", 36'(dct_count), 36'd7);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rst_tw_valid", 36'(tw_valid), 36'd0);
    chk("mid_rst_tw_data", tw_data, 36'd0);
    chk("mid_rst_buffer", 36'(dct_buffer), 36'd0);
    chk("mid_rst_count", 36'(dct_count), 36'd0);
    chk("mid_rst_flush_done", 36'(flush_done), 36'd0);
    step();
    reset = 1'b0;
    tw_ready = 1'b1;
    repeat (5) step();

    chk("queue_empty", 36'(exp_q.size()), 36'd0);
    chk("words_seen", 36'(words_seen), 36'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

// File: doc/cpu_oci_dct_packer.md
Name: cpu_oci_dct_packer

Overview:
- Sequencing controller for the OCI debug-compressed-trace (DCT) buffer.
- Accepts 2-bit trace atoms from the CPU trace front end and packs them into the 30-bit DCT buffer, counting them in the 4-bit DCT count.
- Schedules each full or flushed buffer out as one 36-bit trace word over a valid/ready handshake.
- Exports the live DCT buffer and count to the OCI test bench monitor.

Parameters:
- DEPTH, 15, atoms per trace word; legal range 1..15, with 2*DEPTH <= 30.
- IDLE_FLUSH_CYCLES, 64, idle timeout in cycles before an automatic flush; used only with the optional feature.

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- atom_valid  in  1  trace atom offered
- atom  in  2  trace atom value
- atom_ready  out  1  packer accepts an atom this cycle
- flush  in  1  single-cycle request to emit the partial buffer
- flush_done  out  1  one-cycle pulse when a requested flush completes
- tw_valid  out  1  trace word available
- tw_data  out  36  trace word: [35:34]=2'b01, [33:30]=atom count, [29:0]=buffer
- tw_ready  in  1  consumer takes the word
- dct_buffer  out  30  live packing buffer (monitor)
- dct_count  out  4  live atom count (monitor)

Behaviour:
- Reset values: all outputs 0, pending flush cleared. Reset has priority over every event. Reset mid-operation discards the partial buffer and any undelivered word.
- State machine:
  - FILL: count < DEPTH; atom_ready=1.
  - HOLD: count==DEPTH, or a flush is pending with count>0; atom_ready=0.
  - Transfer condition: in HOLD, when (!tw_valid || tw_ready).
- Atom accept (atom_valid && atom_ready):
  - dct_buffer <= {dct_buffer[27:0], atom}; dct_count <= dct_count+1.
  - Oldest atom sits in the highest occupied pair; unused upper bits stay 0.
- Transfer:
  - Output register loads {2'b01, dct_count, dct_buffer}; tw_valid <= 1.
  - dct_buffer and dct_count clear to 0; state returns to FILL.
  - No atom is accepted in the transfer cycle.
- Latency: the DEPTH-th atom accepted at edge N gives tw_valid=1 after edge N+1 if the output register is free.
- Output register:
  - tw_valid && tw_ready with no new transfer clears tw_valid.
  - A transfer in the same cycle as tw_ready overwrites the register; no bubble and no loss.
  - tw_data holds stable while tw_valid && !tw_ready.
- Flush:
  - The flush pulse sets flush_pend.
  - flush with an accepted atom in the same cycle: the atom is packed first and is included in the flushed word.
  - flush_pend with count==0: clears next cycle, no word emitted, flush_done pulses.
  - flush_pend with count>0: enters HOLD; flush_done pulses in the transfer cycle.
  - flush while already pending: no additional effect.
- Backpressure: while tw_valid=1, tw_ready=0 and the buffer is full, atom_ready stays 0. Atoms are never dropped.
- Counter: dct_count never exceeds DEPTH; no wrap-around.

Optional Feature:
- Macro: DCT_IDLE_FLUSH_EN.
- Defined:
  - An idle counter increments each cycle with count>0 and no atom accepted.
  - It resets on any accepted atom or transfer.
  - On reaching IDLE_FLUSH_CYCLES it sets flush_pend internally.
  - flush_done does not pulse for auto-flushes.
- Undefined: no idle counter; partial words leave only on an explicit flush or when full.

Test Plan:
- Reset, then 15 atoms 2'b11 back-to-back with tw_ready=1 -> tw_valid one cycle after the 15th atom; tw_data=36'h7_FFFF_FFFF (01,1111,all ones); dct_count returns to 0.
- Atoms 01,10,11, then flush -> tw_data={2'b01,4'd3,24'b0,6'b011011}; flush_done pulses in the transfer cycle.
- flush with count=0 -> no tw_valid; flush_done pulses one cycle later.
- tw_ready=0, 30 atoms offered -> first word held stable, second buffer fills, atom_ready=0 at count 15. Raise tw_ready -> both words delivered in consecutive cycles with no atom lost.
- Assert reset after 7 atoms with tw_valid=1 -> next cycle all outputs 0; no word delivered.
- With DCT_IDLE_FLUSH_EN and IDLE_FLUSH_CYCLES=64: 2 atoms, then idle -> word with count=2 emitted about 66 cycles later; flush_done stays 0.
